// File: rtl/quant_gain_loader.sv
// Quantizer gain table loader: decodes the software gain word and writes the gain RAM.
// Optional macro GAIN_SYNC_ALIGN_EN holds each commit until the next sync_in pulse.
module quant_gain_loader #(
   parameter int ADDR_W = 10,
   parameter int GAIN_W = 16
) (
   input  logic              user_clk,
   input  logic              user_rst,
   input  logic [31:0]       ctrl_word,
   input  logic              sync_in,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [GAIN_W-1:0] ram_data,
   output logic              busy,
   output logic              ack_toggle,
   output logic [15:0]       commit_cnt
);

`ifdef GAIN_SYNC_ALIGN_EN
   typedef enum logic [1:0] {IDLE, WAIT_SYNC, WRITE, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
   logic unused_sync;
   assign unused_sync = sync_in;
`endif

   state_t            state;
   logic [31:0]       q1;
   logic [31:0]       q2;
   logic              tog;
   logic              bcast;
   logic              last;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] idx;
   logic [GAIN_W-1:0] gain;
   logic              req;

   // Two matching samples filter out a word caught mid-update by software.
   assign req = (q1 == q2) && (q2[31] != ack_toggle);

   always_ff @(posedge user_clk or posedge user_rst) begin
      if (user_rst) begin
         state      <= IDLE;
         q1         <= '0;
         q2         <= '0;
         tog        <= 1'b0;
         bcast      <= 1'b0;
         last       <= 1'b0;
         addr       <= '0;
         idx        <= '0;
         gain       <= '0;
         ram_we     <= 1'b0;
         ram_addr   <= '0;
         ram_data   <= '0;
         busy       <= 1'b0;
         ack_toggle <= 1'b0;
         commit_cnt <= '0;
      end else begin
         q1 <= ctrl_word;
         q2 <= q1;
         case (state)
            IDLE: begin
               if (req) begin
                  tog   <= q2[31];
                  bcast <= q2[30];
                  addr  <= q2[16 +: ADDR_W];
                  gain  <= q2[0 +: GAIN_W];
                  idx   <= '0;
                  last  <= 1'b0;
                  busy  <= 1'b1;
`ifdef GAIN_SYNC_ALIGN_EN
                  state <= sync_in ? WRITE : WAIT_SYNC;
`else
                  state <= WRITE;
`endif
               end
            end
`ifdef GAIN_SYNC_ALIGN_EN
            WAIT_SYNC: begin
               if (sync_in) begin
                  state <= WRITE;
               end
            end
`endif
            WRITE: begin
               if (last) begin
                  ram_we <= 1'b0;
                  state  <= DONE;
               end else begin
                  ram_we   <= 1'b1;
                  ram_data <= gain;
                  if (bcast) begin
                     ram_addr <= idx;
                     idx      <= idx + ADDR_W'(1);
                     last     <= (idx == '1);
                  end else begin
                     ram_addr <= addr;
                     last     <= 1'b1;
                  end
               end
            end
            DONE: begin
               ack_toggle <= tog;
               commit_cnt <= commit_cnt + 16'd1;
               busy       <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_quant_gain_loader.sv
// Scoreboard bench for quant_gain_loader: expected RAM writes are queued
// at stimulus time and popped by a monitor on every sampled ram_we.
module tb_quant_gain_loader;
   localparam int AW = 10;
   localparam int GW = 16;

   logic          clk = 1'b0;
   logic          user_rst;
   logic [31:0]   ctrl_word;
   logic          sync_in;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [GW-1:0] ram_data;
   logic          busy;
   logic          ack_toggle;
   logic [15:0]   commit_cnt;

   logic [AW+GW-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;
   int we_count = 0;

   quant_gain_loader #(.ADDR_W(AW), .GAIN_W(GW)) dut (
      .user_clk   (clk),
      .user_rst   (user_rst),
      .ctrl_word  (ctrl_word),
      .sync_in    (sync_in),
      .ram_we     (ram_we),
      .ram_addr   (ram_addr),
      .ram_data   (ram_data),
      .busy       (busy),
      .ack_toggle (ack_toggle),
      .commit_cnt (commit_cnt)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      logic [AW+GW-1:0] e;
      if (!user_rst && ram_we) begin
         we_count++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL write_unexpected got addr=%0d data=%h", ram_addr, ram_data);
         end else begin
            e = exp_q.pop_front();
            if ({ram_addr, ram_data} !== e) begin
               errors++;
               $display("FAIL write_data got addr=%0d data=%h want addr=%0d data=%h",
                        ram_addr, ram_data, e[AW+GW-1:GW], e[GW-1:0]);
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wait_busy(input logic level, input int limit);
      int n = 0;
      while (busy !== level && n < limit) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (busy !== level) begin
         errors++;
         $display("FAIL busy_timeout got %b want %b", busy, level);
      end
   endtask

   task automatic check_queue(input string tag);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_pending got %0d writes left want 0", tag, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      user_rst  = 1'b1;
      ctrl_word = '0;
      sync_in   = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({ram_we, ram_addr, ram_data, busy, ack_toggle, commit_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got we=%b a=%0d d=%h b=%b ack=%b cnt=%0d want all 0",
                  ram_we, ram_addr, ram_data, busy, ack_toggle, commit_cnt);
      end
      @(posedge clk);
      #1 user_rst = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || we_count != 0) begin
         errors++;
         $display("FAIL reset_idle got busy=%b writes=%0d want 0 0", busy, we_count);
      end
   endtask

   task automatic test_single();
      bit eb [6] = '{0, 0, 1, 1, 1, 0};
      bit ew [6] = '{0, 0, 0, 1, 0, 0};
      @(posedge clk);
      #1 ctrl_word = 32'h8005_1234;
      exp_q.push_back({AW'(5), GW'(16'h1234)});
      @(posedge clk);
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         checks++;
         if (busy !== eb[n] || ram_we !== ew[n]) begin
            errors++;
            $display("FAIL single_timing cycle k+%0d got busy=%b we=%b want %b %b",
                     n, busy, ram_we, eb[n], ew[n]);
         end
      end
      checks++;
      if (ack_toggle !== 1'b1 || commit_cnt !== 16'd1) begin
         errors++;
         $display("FAIL single_retire got ack=%b cnt=%0d want 1 1", ack_toggle, commit_cnt);
      end
      check_queue("single");
   endtask

   task automatic test_broadcast();
      int len = 0;
      int w0;
      @(posedge clk);
      #1 ctrl_word = 32'h4000_00FF;
      w0 = we_count;
      for (int i = 0; i < (1 << AW); i++)
         exp_q.push_back({AW'(i), GW'(16'h00FF)});
      exp_q.push_back({AW'(7), GW'(16'h0042)});
      wait_busy(1'b1, 10);
      while (busy === 1'b1 && len < 3000) begin
         len++;
         if (len == 100)
            ctrl_word = 32'h8007_0042;
         @(negedge clk);
      end
      checks++;
      if (len != 1026) begin
         errors++;
         $display("FAIL bcast_busy_len got %0d want 1026", len);
      end
      checks++;
      if (ack_toggle !== 1'b0 || commit_cnt !== 16'd2 || we_count - w0 != 1024) begin
         errors++;
         $display("FAIL bcast_retire got ack=%b cnt=%0d writes=%0d want 0 2 1024",
                  ack_toggle, commit_cnt, we_count - w0);
      end
      wait_busy(1'b1, 10);
      wait_busy(1'b0, 20);
      repeat (5) @(negedge clk);
      checks++;
      if (ack_toggle !== 1'b1 || commit_cnt !== 16'd3 || we_count - w0 != 1025) begin
         errors++;
         $display("FAIL overlap_retire got ack=%b cnt=%0d writes=%0d want 1 3 1025",
                  ack_toggle, commit_cnt, we_count - w0);
      end
      check_queue("bcast");
   endtask

   task automatic test_stability();
      int w0;
      user_rst  = 1'b1;
      ctrl_word = '0;
      repeat (2) @(posedge clk);
      #1 user_rst = 1'b0;
      w0 = we_count;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk);
         #1 ctrl_word = 32'h8000_0000 | (32'(i) << 16) | 32'(i);
      end
      @(posedge clk);
      #1 ctrl_word = 32'h8003_0010;
      @(negedge clk);
      checks++;
      if (we_count != w0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL stable_filter got writes=%0d busy=%b want 0 0", we_count - w0, busy);
      end
      exp_q.push_back({AW'(3), GW'(16'h0010)});
      wait_busy(1'b1, 10);
      wait_busy(1'b0, 20);
      checks++;
      if (ack_toggle !== 1'b1 || commit_cnt !== 16'd1 || we_count - w0 != 1) begin
         errors++;
         $display("FAIL stable_retire got ack=%b cnt=%0d writes=%0d want 1 1 1",
                  ack_toggle, commit_cnt, we_count - w0);
      end
      check_queue("stable");
   endtask

   task automatic test_reset_mid_broadcast();
      int n = 0;
      int w0;
      @(posedge clk);
      #1 ctrl_word = 32'h4000_0ABC;
      for (int i = 0; i < (1 << AW); i++)
         exp_q.push_back({AW'(i), GW'(16'h0ABC)});
      @(negedge clk);
      while (!(ram_we === 1'b1 && ram_addr === AW'(500)) && n < 1200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (ram_addr !== AW'(500)) begin
         errors++;
         $display("FAIL rst_mid_reach got addr=%0d want 500", ram_addr);
      end
      #1 user_rst = 1'b1;
      #1;
      checks++;
      if ({ram_we, ram_addr, ram_data, busy, ack_toggle, commit_cnt} !== '0) begin
         errors++;
         $display("FAIL rst_mid_outputs got we=%b a=%0d d=%h b=%b ack=%b cnt=%0d want all 0",
                  ram_we, ram_addr, ram_data, busy, ack_toggle, commit_cnt);
      end
      exp_q.delete();
      ctrl_word = 32'h8009_0077;
      exp_q.push_back({AW'(9), GW'(16'h0077)});
      repeat (2) @(posedge clk);
      #1 user_rst = 1'b0;
      w0 = we_count;
      wait_busy(1'b1, 10);
      wait_busy(1'b0, 20);
      checks++;
      if (ack_toggle !== 1'b1 || commit_cnt !== 16'd1 || we_count - w0 != 1) begin
         errors++;
         $display("FAIL rst_mid_fresh got ack=%b cnt=%0d writes=%0d want 1 1 1",
                  ack_toggle, commit_cnt, we_count - w0);
      end
      check_queue("rst_mid");
   endtask

`ifdef GAIN_SYNC_ALIGN_EN
   task automatic test_sync_align();
      int w0;
      @(posedge clk);
      #1 ctrl_word = 32'h0002_0033;
      exp_q.push_back({AW'(2), GW'(16'h0033)});
      w0 = we_count;
      wait_busy(1'b1, 10);
      repeat (20) @(negedge clk);
      checks++;
      if (busy !== 1'b1 || we_count != w0) begin
         errors++;
         $display("FAIL sync_hold got busy=%b writes=%0d want 1 0", busy, we_count - w0);
      end
      @(posedge clk);
      #1 sync_in = 1'b1;
      @(posedge clk);
      #1 sync_in = 1'b0;
      @(negedge clk);
      checks++;
      if (ram_we !== 1'b0) begin
         errors++;
         $display("FAIL sync_early got we=%b want 0", ram_we);
      end
      @(negedge clk);
      checks++;
      if (ram_we !== 1'b1) begin
         errors++;
         $display("FAIL sync_write got we=%b want 1", ram_we);
      end
      wait_busy(1'b0, 20);
      check_queue("sync");
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_broadcast();
      test_stability();
      test_reset_mid_broadcast();
`ifdef GAIN_SYNC_ALIGN_EN
      test_sync_align();
`endif
      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/quant_gain_loader.md
Name: quant_gain_loader

Overview:
- Controller for the quantizer gain table, running in the user clock domain.
- Decodes the 32-bit software gain register word and sequences writes into the per-channel gain RAM that the quantizer datapath reads.
- Two commit types: single-channel write, or broadcast fill of all channels.
- Returns an acknowledge toggle and a commit counter for software readback.

Parameters:
- ADDR_W, 10, channel address width; table depth is 2^ADDR_W; legal range 1..14.
- GAIN_W, 16, gain coefficient width; legal range 1..16.

Ports:
- user_clk  in  1  block clock; all logic is rising-edge.
- user_rst  in  1  asynchronous, active-high reset.
- ctrl_word  in  32  software gain register word, quasi-static.
  - [31] commit toggle.
  - [30] broadcast.
  - [29:16] channel address; low ADDR_W bits used.
  - [15:0] gain; low GAIN_W bits used.
- sync_in  in  1  spectrum/frame sync pulse; used only with GAIN_SYNC_ALIGN_EN.
- ram_we  out  1  gain RAM write enable.
- ram_addr  out  ADDR_W  gain RAM write address.
- ram_data  out  GAIN_W  gain RAM write data.
- busy  out  1  high from commit detection until the commit retires.
- ack_toggle  out  1  copy of bit 31 of the last serviced commit.
- commit_cnt  out  16  count of retired commits; wraps from 65535 to 0.

Behaviour:
- Reset values: all outputs 0; state IDLE; q1, q2 and latched fields 0. Assertion forces ram_we low immediately.
- Input capture: every cycle q1 <= ctrl_word, q2 <= q1. The word is stable when q1 == q2.
- States:
  - IDLE: if stable and q2[31] != ack_toggle, latch q2 fields as tog, bcast, addr, gain; set busy=1; go to WRITE (WAIT_SYNC when the feature is enabled). Otherwise stay.
  - WRITE, single (bcast=0): ram_we=1, ram_addr=addr, ram_data=gain for exactly 1 cycle, then DONE.
  - WRITE, broadcast (bcast=1): ram_we=1 for 2^ADDR_W consecutive cycles; ram_addr runs 0,1,...,2^ADDR_W-1; ram_data=gain constant; then DONE.
  - DONE: ram_we=0; ack_toggle<=tog; commit_cnt<=commit_cnt+1; busy<=0; go to IDLE.
- Outputs ram_we, ram_addr, ram_data and busy are registered. Between writes, ram_addr and ram_data hold their last values.
- Latency: ctrl_word changes before edge k, so q1 updates at k and q2 at k+1.
  - Detection and busy=1 at edge k+2.
  - ram_we high after edge k+3.
  - For a single commit: ram_we falls at k+4; ack_toggle, commit_cnt and busy update at k+5.
- Changes to ctrl_word while busy are ignored. Detection is re-evaluated only in IDLE, so a toggle flipped during busy is serviced afterwards.
- A toggle flipped twice while busy nets to no change and is not serviced. Software must poll ack_toggle before the next commit.
- Unused address/gain bits are ignored. The address field is truncated, never wrapped or saturated.
- After reset, ack_toggle=0. A stable ctrl_word with bit31=1 therefore triggers one commit; this is intended.
- Reset mid-broadcast abandons the fill with a partial table written; commit_cnt and ack_toggle return to 0.

Optional Feature:
- GAIN_SYNC_ALIGN_EN defined:
  - After detection, enter WAIT_SYNC with busy=1 and ram_we=0.
  - On the first cycle sync_in=1 is sampled, go to WRITE; first ram_we is the following cycle.
  - A sync_in already high at detection counts.
  - Keeps gain updates aligned to spectrum boundaries.
- Not defined: WAIT_SYNC does not exist; sync_in is ignored; IDLE goes straight to WRITE.

Test Plan:
- Single write: reset, then ctrl_word=0x8005_1234 with ADDR_W=10, GAIN_W=16 -> one ram_we pulse with addr=5, data=0x1234, 3 cycles after the change; then ack_toggle=1, commit_cnt=1, busy=0.
- Broadcast: ctrl_word=0x4000_00FF, i.e. toggle 0→... from ack=1 -> 1024 consecutive ram_we cycles, addr 0..1023, data 0x00FF; busy high for 1026 cycles total; ack_toggle=0, commit_cnt=2.
- Busy overlap: mid-broadcast, flip toggle with addr=7, gain=0x0042 -> ignored until DONE; then exactly one single write to addr 7 with data 0x0042; commit_cnt=3.
- Stability filter: change ctrl_word on every cycle for 10 cycles -> no ram_we; then hold 0x8003_0010 -> one write to addr 3, data 0x0010.
- Reset mid-broadcast: assert user_rst at addr 500 -> ram_we=0 asynchronously; all outputs 0. Release with a stable word whose bit31=1 -> a fresh commit starts; commit_cnt=1.
- GAIN_SYNC_ALIGN_EN: commit with sync_in held low for 20 cycles -> busy=1, no ram_we. Pulse sync_in -> ram_we the next cycle.
